// File: rtl/demux_router_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
// Channel count, select width, statistics width and channel state.
package demux_router_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int STAT_W = 8;

  typedef enum logic {
    CH_EMPTY,
    CH_FULL
  } ch_state_t;

endpackage

// File: rtl/demux_ch_slot.sv
// One-entry output holding register with valid/ready drain.
// Ports: clk, rst, load/load_data (capture), out_ready/out_valid/out_data
// (consumer handshake), stat_cnt (drain count, DEMUX_ROUTER_STATS_EN).
module demux_ch_slot
  import demux_router_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [STAT_W-1:0] stat_cnt
);

  ch_state_t         state;
  logic [DATA_W-1:0] data_q;
  logic              drain;

  assign drain     = (state == CH_FULL) && out_ready;
  assign out_valid = (state == CH_FULL);
  assign out_data  = data_q;

  // A load in the same cycle as a drain keeps the slot full,
  // so one word per cycle can stream through.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CH_EMPTY;
      data_q <= '0;
    end else if (load) begin
      state  <= CH_FULL;
      data_q <= load_data;
    end else if (drain) begin
      state  <= CH_EMPTY;
    end
  end

`ifdef DEMUX_ROUTER_STATS_EN
  logic [STAT_W-1:0] cnt_q;

  // Saturating: sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (drain && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stat_cnt = cnt_q;
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: rtl/demux_router_1x4.sv
// Registered 1-to-4 stream demux: routes in_data to the slot picked by in_sel.
// Ports: clk, rst, in_* (producer), out_* (4 consumers), stat_cnt.
// Optional drain counters: define DEMUX_ROUTER_STATS_EN.
module demux_router_1x4
  import demux_router_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*STAT_W-1:0] stat_cnt
);

  logic [NUM_CH-1:0] load;
  logic              xfer;

  // Combinational from in_sel/out_ready: a full slot that is
  // draining this cycle can take a new word.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  assign xfer     = in_valid && in_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign load[c] = xfer && (in_sel == SEL_W'(c));

    demux_ch_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[c]),
      .load_data(in_data),
      .out_ready(out_ready[c]),
      .out_valid(out_valid[c]),
      .out_data (out_data[c*DATA_W +: DATA_W]),
      .stat_cnt (stat_cnt[c*STAT_W +: STAT_W])
    );
  end

endmodule

// File: tb/tb_demux_router_1x4.sv
// Self-checking bench for demux_router_1x4: queue-based channel model
// compared every cycle, plus literal expectations for directed vectors.
module tb_demux_router_1x4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] stat_cnt;

  int checks = 0;
  int failures = 0;

  demux_router_1x4 #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .stat_cnt (stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a FIFO of depth at most one.
  logic [7:0] mq[4][$];
  logic [7:0] mlast[4];
  int         mcnt[4];
  logic [7:0] log1[$];
  bit         started = 0;

  function automatic logic m_ready();
    return (mq[in_sel].size() == 0) || out_ready[in_sel];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        mq[c].delete();
        mlast[c] = 8'h00;
        mcnt[c] = 0;
      end
      started = 1;
    end else begin
      logic acc;
      acc = in_valid && m_ready();
      for (int c = 0; c < 4; c++) begin
        if (mq[c].size() > 0 && out_ready[c]) begin
          logic [7:0] w;
          w = mq[c].pop_front();
          if (c == 1) log1.push_back(w);
          if (mcnt[c] < 255) mcnt[c]++;
        end
      end
      if (acc) begin
        mq[in_sel].push_back(in_data);
        mlast[in_sel] = in_data;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [3:0]  ev;
      logic [31:0] ed;
      logic [31:0] es;
      for (int c = 0; c < 4; c++) begin
        ev[c] = mq[c].size() > 0;
        ed[c*8 +: 8] = mlast[c];
`ifdef DEMUX_ROUTER_STATS_EN
        es[c*8 +: 8] = 8'(mcnt[c]);
`else
        es[c*8 +: 8] = 8'h00;
`endif
      end
      chk("cyc_out_valid", {28'd0, out_valid}, {28'd0, ev});
      chk("cyc_out_data", out_data, ed);
      chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
      chk("cyc_stat_cnt", stat_cnt, es);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 4'b0000;
    in_valid = 1'b0;
    in_sel = 2'd0;
    in_data = 8'h00;
    repeat (2) tick();
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_stat_cnt", stat_cnt, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    end
    rst = 1'b0;
    tick();

    // Basic routing and backpressure on ch2
    in_sel = 2'd2;
    in_data = 8'hA5;
    in_valid = 1'b1;
    tick();
    chk("route_valid", {28'd0, out_valid}, 32'h4);
    chk("route_data", {24'd0, out_data[23:16]}, 32'hA5);
    in_data = 8'h5A;
    #1;
    chk("route_blocked", {31'd0, in_ready}, 32'd0);
    repeat (2) tick();
    chk("route_hold", {24'd0, out_data[23:16]}, 32'hA5);
    out_ready = 4'b0100;
    #1;
    chk("route_unblock", {31'd0, in_ready}, 32'd1);
    tick();
    chk("route_second", {24'd0, out_data[23:16]}, 32'h5A);
    chk("route_second_v", {31'd0, out_valid[2]}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("route_drained", {28'd0, out_valid}, 32'd0);
    out_ready = 4'b0000;

    // Full-rate streaming on ch1
    out_ready = 4'b0010;
    in_sel = 2'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i);
      #1;
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("stream_lat", {24'd0, out_data[15:8]}, 32'(i));
    end
    in_valid = 1'b0;
    repeat (2) tick();
    chk("stream_count", 32'(log1.size()), 32'd16);
    for (int i = 0; i < 16 && i < log1.size(); i++)
      chk("stream_order", {24'd0, log1[i]}, 32'(i));
    out_ready = 4'b0000;

    // Independent backpressure
    in_sel = 2'd0;
    in_data = 8'h77;
    in_valid = 1'b1;
    tick();
    out_ready = 4'b1110;
    for (int c = 1; c < 4; c++) begin
      in_sel = 2'(c);
      in_data = 8'(c * 8'h11);
      #1;
      chk("indep_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("indep_valid", {28'd0, out_valid}, 32'h1);
    chk("indep_ch0", {24'd0, out_data[7:0]}, 32'h77);
    chk("indep_ch3", {24'd0, out_data[31:24]}, 32'h33);
    out_ready = 4'b1111;
    tick();
    chk("indep_drain", {28'd0, out_valid}, 32'd0);
    out_ready = 4'b0000;

    // Reset mid-operation with all channels full
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_sel = 2'(c);
      in_data = 8'(8'hC0 + c);
      tick();
    end
    in_valid = 1'b0;
    chk("midrst_full", {28'd0, out_valid}, 32'hF);
    rst = 1'b1;
    out_ready = 4'b1111;
    tick();
    rst = 1'b0;
    chk("midrst_valid", {28'd0, out_valid}, 32'd0);
    chk("midrst_stat", stat_cnt, 32'd0);
    tick();
    chk("midrst_stat2", stat_cnt, 32'd0);
    out_ready = 4'b0000;

    // Saturation: 300 drains on ch3
    out_ready = 4'b1000;
    in_sel = 2'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
`ifdef DEMUX_ROUTER_STATS_EN
    chk("stat_sat", stat_cnt, 32'hFF00_0000);
`else
    chk("stat_off", stat_cnt, 32'd0);
`endif
    chk("stat_idle", {28'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
